// File: rtl/serial_adder8_if.sv
// rtl/serial_adder8_if.sv - start/busy/done handshake bundle for the bit-serial adder
interface serial_adder8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder8.sv
// rtl/serial_adder8.sv - bit-serial unsigned adder, one full-adder stage reused WIDTH times
module serial_adder8 #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder8_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             carry;
    logic [CW-1:0]    count;
    logic             accept;
    logic             last;
    logic             bit_sum;
    logic             carry_next;

    // one full-adder stage working on the current LSBs
    always_comb begin
        bit_sum    = op_a[0] ^ op_b[0] ^ carry;
        carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next state; DONE accepts a new start directly so back-to-back runs skip IDLE
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (count == CW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // operand capture, serial shifting and result publication on the final bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else if (accept) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            carry <= 1'b0;
            count <= '0;
        end else if (state == SHIFT) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= carry_next;
            res   <= {bit_sum, res[WIDTH-1:1]};
            count <= count + 1'b1;
            if (last) begin
                sum_r  <= {bit_sum, res[WIDTH-1:1]};
                cout_r <= carry_next;
            end
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_adder8.sv
// tb/tb_serial_adder8.sv - directed scoreboard bench for serial_adder8
module tb_serial_adder8;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [8:0] exp_q[$];

    serial_adder8_if #(.WIDTH(8)) bus ();

    serial_adder8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive one accepted start and push its expected result
    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        exp_q.push_back({1'b0, av} + {1'b0, bv});
        tick();
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    // wait (bounded) for done, check latency and pop/compare the scoreboard
    task automatic wait_done(input string tag);
        int n;
        logic [8:0] e;
        n = 0;
        do begin
            if (n > 0 || !bus.done) begin
                if (n > 0) check({tag, "_nodone_early"}, 32'(bus.done), 32'd0);
            end
            tick();
            n++;
        end while (!bus.done && n < 20);
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_sum"}, 32'(bus.sum), 32'(e[7:0]));
                check({tag, "_cout"}, 32'(bus.cout), 32'(e[8]));
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        tick();

        // basic add
        launch(8'h25, 8'h13);
        bus.start = 1'b0;
        wait_done("basic");
        tick();
        check("basic_done_pulse", 32'(bus.done), 32'd0);
        check("basic_idle_busy", 32'(bus.busy), 32'd0);

        // hold after done
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_sum", 32'(bus.sum), 32'h38);
            check("hold_cout", 32'(bus.cout), 32'd0);
            check("hold_done", 32'(bus.done), 32'd0);
            check("hold_busy", 32'(bus.busy), 32'd0);
        end

        // carry ripple cases
        launch(8'hFF, 8'h01);
        bus.start = 1'b0;
        wait_done("ripple_ff01");
        tick();
        launch(8'h80, 8'h80);
        bus.start = 1'b0;
        wait_done("ripple_8080");
        tick();
        launch(8'h00, 8'h00);
        bus.start = 1'b0;
        wait_done("ripple_zero");
        tick();

        // operand isolation and start while busy
        launch(8'h0F, 8'hF0);
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        bus.start = 1'b0;
        check("iso_busy_mid", 32'(bus.busy), 32'd1);
        begin
            int n;
            logic [8:0] e;
            n = 3;
            while (!bus.done && n < 20) begin
                tick();
                n++;
            end
            check("iso_latency", 32'(n), 32'd8);
            e = exp_q.pop_front();
            check("iso_sum", 32'(bus.sum), 32'(e[7:0]));
            check("iso_cout", 32'(bus.cout), 32'(e[8]));
        end
        tick();
        check("iso_no_restart_busy", 32'(bus.busy), 32'd0);
        check("iso_no_restart_done", 32'(bus.done), 32'd0);

        // back-to-back with start held high
        launch(8'h7F, 8'h01);
        wait_done("b2b_first");
        launch(8'hC8, 8'h64);
        bus.start = 1'b0;
        wait_done("b2b_second");
        tick();

        // reset in the 4th shift cycle
        launch(8'h33, 8'h44);
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
        launch(8'h01, 8'h02);
        bus.start = 1'b0;
        wait_done("after_abort");
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder8.md
Name: serial_adder8

Overview:
- Bit-serial 8-bit unsigned adder with a start/busy/done handshake; computes a + b with one full-adder stage reused over WIDTH cycles.
- Forward (addition) counterpart to the combinational 8-bit ripple subtractor in the lab arithmetic set.
- Used where area matters more than latency. Sits between operand registers and any consumer of the result.

Parameters:
- WIDTH, 8, operand and result width in bits; the counter is sized to hold the value WIDTH.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- start  input  1  request to begin an addition; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high while the state is SHIFT.
- done  output  1  one-cycle pulse marking that sum/cout are newly valid.
- sum  output  WIDTH  result (a + b) mod 2^WIDTH; registered.
- cout  output  1  carry out of the MSB; registered.

Behaviour:
- Reset: rst_n low at a clock edge sets state to IDLE, busy=0, done=0, sum=0, cout=0, and clears all internal operand, carry and count registers. Reset overrides start.
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE:
  - start=1 at edge k: capture a and b into shift registers, clear the internal carry, set count=0, go to SHIFT.
  - busy=1 from edge k onward.
- SHIFT: each edge processes one bit, LSB first.
  - Bit sum = opA[0] ^ opB[0] ^ carry.
  - carry <= majority(opA[0], opB[0], carry).
  - Both operand registers shift right by one.
  - The bit sum shifts into the MSB of an internal result register.
  - count increments.
  - Edges k+1 … k+WIDTH process bits 0 … WIDTH-1.
- Completion, at edge k+WIDTH:
  - sum is loaded with the full internal result, including bit WIDTH-1 computed on that edge.
  - cout is loaded with the final carry.
  - State goes to DONE; done=1, busy=0.
  - Total latency: done high during cycle k+WIDTH, i.e. 8 cycles after start is sampled for WIDTH=8.
- DONE: lasts exactly one cycle.
  - start=0: go to IDLE, done=0.
  - start=1: accept new operands exactly as in IDLE and go to SHIFT. This gives back-to-back throughput of one result per WIDTH+1 cycles.
- Output stability: sum and cout change only at the completion edge or at reset. They hold the last result through IDLE and through any subsequent SHIFT.
- Ignored inputs:
  - start during SHIFT is ignored; no queuing, no restart.
  - a and b are don't-care except on the accepting edge; changes during SHIFT have no effect.
- Overflow: unsigned wrap-around. Overflow is reported only via cout; no saturation.
- Reset mid-SHIFT: the operation is aborted and no done pulse is produced. sum/cout become 0.

Test Plan:
- Basic add: reset, then start with a=0x25, b=0x13 -> busy=1 for 8 cycles, then done pulses 1 cycle with sum=0x38, cout=0; busy=0 afterwards.
- Carry ripple: start with a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1. Then a=0x00, b=0x00 -> sum=0x00, cout=0.
- Operand isolation and start-while-busy: start with a=0x0F, b=0xF0; on the next cycle change a=0xAA, b=0x55 and hold start=1 for 3 cycles -> single done after 8 cycles with sum=0xFF, cout=0; no second operation begins.
- Back-to-back: hold start=1 with a=0x7F, b=0x01, then on the DONE cycle present a=0xC8, b=0x64 -> first done gives sum=0x80, cout=0. busy re-asserts the next cycle without passing through IDLE. Second done follows 9 cycles after the first with sum=0x2C, cout=1.
- Reset mid-operation: start with a=0x33, b=0x44; assert rst_n=0 on the 4th SHIFT cycle for 1 cycle -> busy=0, done never pulses, sum=0x00, cout=0. A subsequent start with a=0x01, b=0x02 yields sum=0x03.
- Hold after done: after a completed 0x25+0x13, leave start=0 for 20 cycles -> sum stays 0x38, cout stays 0, done stays 0, busy stays 0.
